// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: scans a snapshot of a 16x16 bicolor frame into the
// column shift registers row by row. Optional: LED_BRIGHTNESS_EN (BRIGHT dimming).
module led_matrix_scanner #(
  parameter int CLK_DIV      = 2,
  parameter int DWELL_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [15:0][15:0] RedPixels,
  input  logic [15:0][15:0] GrnPixels,
`ifdef LED_BRIGHTNESS_EN
  input  logic [2:0]        BRIGHT,
`endif
  output logic              SER_CLK,
  output logic              SER_DAT_R,
  output logic              SER_DAT_G,
  output logic              SER_LAT,
  output logic              OE_N,
  output logic [3:0]        ROW_SEL,
  output logic              FRAME_DONE
);

  localparam int DIVW = $clog2(2 * CLK_DIV);
  localparam int DWW  = $clog2(DWELL_CYCLES);

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(2 * CLK_DIV - 1);
  localparam logic [DIVW-1:0] DIV_HALF = DIVW'(CLK_DIV);
  localparam logic [DWW-1:0]  DW_LAST  = DWW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DWELL
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        row_q, row_d;
  logic [3:0]        bit_q, bit_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic [DWW-1:0]    dwell_q, dwell_d;
  logic [15:0][15:0] bufr_q, bufr_d;
  logic [15:0][15:0] bufg_q, bufg_d;
  logic [3:0]        rowsel_q, rowsel_d;
  logic              fdone_q, fdone_d;
  logic              oe_dwell;

`ifdef LED_BRIGHTNESS_EN
  localparam logic [DWW+3:0] DW_LEN = (DWW + 4)'(DWELL_CYCLES);

  logic [2:0]     bright_q, bright_d;
  logic [DWW+3:0] lvl;
  logic [DWW+3:0] on_lim;

  // Dwell cycles with columns enabled: floor((BRIGHT+1)*DWELL/8)
  always_comb begin
    lvl      = {{(DWW + 1){1'b0}}, bright_q} + {{(DWW + 3){1'b0}}, 1'b1};
    on_lim   = (lvl * DW_LEN) >> 3;
    oe_dwell = !({4'b0, dwell_q} < on_lim);
  end
`else
  // Columns enabled for the whole dwell
  always_comb begin
    oe_dwell = 1'b0;
  end
`endif

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= S_LOAD;
      row_q    <= 4'd0;
      bit_q    <= 4'd15;
      div_q    <= '0;
      dwell_q  <= '0;
      bufr_q   <= '0;
      bufg_q   <= '0;
      rowsel_q <= 4'd0;
      fdone_q  <= 1'b0;
`ifdef LED_BRIGHTNESS_EN
      bright_q <= 3'd7;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      dwell_q  <= dwell_d;
      bufr_q   <= bufr_d;
      bufg_q   <= bufg_d;
      rowsel_q <= rowsel_d;
      fdone_q  <= fdone_d;
`ifdef LED_BRIGHTNESS_EN
      bright_q <= bright_d;
`endif
    end
  end

  // Scan sequencer: next state and pin drive
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    bit_d     = bit_q;
    div_d     = div_q;
    dwell_d   = dwell_q;
    bufr_d    = bufr_q;
    bufg_d    = bufg_q;
    rowsel_d  = rowsel_q;
    fdone_d   = 1'b0;
`ifdef LED_BRIGHTNESS_EN
    bright_d  = bright_q;
`endif
    SER_CLK   = 1'b0;
    SER_DAT_R = 1'b0;
    SER_DAT_G = 1'b0;
    SER_LAT   = 1'b0;
    OE_N      = 1'b1;
    unique case (state_q)
      S_LOAD: begin
        bit_d   = 4'd15;
        div_d   = '0;
        if (row_q == 4'd0) begin
          bufr_d = RedPixels;
          bufg_d = GrnPixels;
        end
`ifdef LED_BRIGHTNESS_EN
        bright_d = BRIGHT;
`endif
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        SER_DAT_R = bufr_q[row_q][bit_q];
        SER_DAT_G = bufg_q[row_q][bit_q];
        SER_CLK   = (div_q >= DIV_HALF);
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == 4'd0) begin
            state_d = S_BLANK;
          end else begin
            bit_d = bit_q - 4'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_BLANK: begin
        rowsel_d = row_q;
        state_d  = S_LATCH;
      end
      S_LATCH: begin
        SER_LAT = 1'b1;
        dwell_d = '0;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        OE_N = oe_dwell;
        if (dwell_q == DW_LAST) begin
          dwell_d = '0;
          row_d   = row_q + 4'd1;
          fdone_d = (row_q == 4'd15);
          state_d = S_LOAD;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  assign ROW_SEL    = rowsel_q;
  assign FRAME_DONE = fdone_q;

endmodule
